// File: rtl/cic_pkg.sv
// Constants shared by the CIC decimator and its downstream sample FIFO.
package cic_pkg;
  localparam int CIC_W      = 32;
  localparam int SAMPLE_W   = 16;
  localparam int SHIFT_W    = 5;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head entry is visible on rd_data while not empty.
module sync_fifo_fwft #(
  parameter  int W     = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_rd, do_wr;

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  // Storage is not reset, so the head is masked to keep the output clean while empty.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/cic_sample_fifo.sv
// CIC output stage: shift/saturate each decimated sample, queue it in a FWFT FIFO,
// and track samples lost when the consumer falls behind.
module cic_sample_fifo
  import cic_pkg::*;
#(
  parameter  int IN_W  = CIC_W,
  parameter  int OUT_W = SAMPLE_W,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_vld,
  input  logic [SHIFT_W-1:0]    shift,
  output logic [OUT_W-1:0]      m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [AW:0]           level,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  clr_ovf
);
  logic [IN_W-1:0]  shifted;
  logic [OUT_W-1:0] sat_val, stg_data;
  logic             stg_vld, empty, full, rd, wr, drop;

  assign shifted = in_data >> shift;
  assign sat_val = (|shifted[IN_W-1:OUT_W]) ? '1 : shifted[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_vld  <= 1'b0;
      stg_data <= '0;
    end else begin
      stg_vld <= in_vld;
      if (in_vld) stg_data <= sat_val;
    end
  end

  // A full FIFO still accepts the staged sample if the head leaves this cycle.
  assign m_valid = ~empty;
  assign rd      = m_valid & m_ready;
  assign wr      = stg_vld & (~full | rd);
  assign drop    = stg_vld & full & ~rd;

  sync_fifo_fwft #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr),
    .wr_data (stg_data),
    .rd_en   (rd),
    .rd_data (m_data),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

  // A drop coinciding with clr_ovf restarts the count at one rather than being lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)            drop_cnt <= DROP_CNT_W'(1);
      else if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_cic_sample_fifo.sv
// Directed bench for cic_sample_fifo: scaling, latency, overflow, full read+write, clear, reset.
module tb_cic_sample_fifo;
  logic        clk, rst;
  logic [31:0] in_data;
  logic        in_vld;
  logic [4:0]  shift;
  logic [15:0] m_data;
  logic        m_valid, m_ready;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        clr_ovf;

  int n_chk = 0;
  int n_pass = 0;

  cic_sample_fifo dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .shift(shift),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s act=%h exp=%h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {in_data, shift, expected m_data}
  logic [31:0] sc_in  [6] = '{32'h0000_1230, 32'h0001_0000, 32'h000F_FFF0,
                              32'h0010_0000, 32'h1234_5678, 32'hFFFF_FFFF};
  logic [4:0]  sc_sh  [6] = '{5'd4, 5'd0, 5'd4, 5'd4, 5'd16, 5'd31};
  logic [15:0] sc_exp [6] = '{16'h0123, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h0001};

  initial begin
    rst = 1'b0; in_data = '0; in_vld = 1'b0; shift = '0; m_ready = 1'b0; clr_ovf = 1'b0;
    #3;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_m_data", 32'(m_data), 0);
    step(); step();
    rst = 1'b1;
    step();

    // Scaling and saturation, one sample at a time
    for (int i = 0; i < 6; i++) begin
      in_data = sc_in[i]; shift = sc_sh[i]; in_vld = 1'b1;
      step();
      in_vld = 1'b0;
      step();
      chk($sformatf("scale%0d_valid", i), 32'(m_valid), 1);
      chk($sformatf("scale%0d_data", i), 32'(m_data), 32'(sc_exp[i]));
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
    end
    chk("scale_empty", 32'(level), 0);

    // Latency and ordering with the consumer always ready
    shift = '0; m_ready = 1'b1;
    in_data = 1; in_vld = 1'b1;
    step();
    chk("lat_not_yet", 32'(m_valid), 0);
    in_data = 2;
    step();
    chk("lat_valid", 32'(m_valid), 1);
    chk("ord_1", 32'(m_data), 1);
    in_data = 3;
    step();
    chk("ord_2", 32'(m_data), 2);
    in_vld = 1'b0;
    step();
    chk("ord_3", 32'(m_data), 3);
    step();
    chk("ord_empty", 32'(m_valid), 0);
    chk("ord_level", 32'(level), 0);

    // Overflow: 20 samples into a 16-deep FIFO with no reads
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'(i * 3 + 5); in_vld = 1'b1;
      step();
    end
    in_vld = 1'b0;
    step(); step();
    chk("ovf_level", 32'(level), 16);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drop_cnt", 32'(drop_cnt), 4);
    chk("ovf_head", 32'(m_data), 5);

    // Full read+write: staged sample lands at the tail while the head leaves
    in_data = 32'h0ABC; in_vld = 1'b1;
    step();
    in_vld = 1'b0; m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("frw_level", 32'(level), 16);
    chk("frw_drop_cnt", 32'(drop_cnt), 4);
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d", k), 32'(m_data), (k < 15) ? 32'((k + 1) * 3 + 5) : 32'h0ABC);
      step();
    end
    m_ready = 1'b0;
    chk("drain_empty", 32'(m_valid), 0);
    chk("drain_level", 32'(level), 0);

    // clr_ovf coincident with a drop, then on its own
    for (int i = 0; i < 16; i++) begin
      in_data = 32'h200 + 32'(i); in_vld = 1'b1;
      step();
    end
    in_vld = 1'b0;
    step();
    chk("clr_fill_level", 32'(level), 16);
    in_data = 32'h999; in_vld = 1'b1;
    step();
    in_vld = 1'b0; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_drop_ovf", 32'(overflow), 1);
    chk("clr_drop_cnt", 32'(drop_cnt), 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_cnt", 32'(drop_cnt), 0);
    chk("clr_level", 32'(level), 16);

    // Asynchronous reset mid-stream with 5 entries queued and a sample staged
    in_data = 32'h777; in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    step();
    chk("pre_rst_drop_cnt", 32'(drop_cnt), 1);
    m_ready = 1'b1;
    repeat (11) step();
    m_ready = 1'b0;
    chk("pre_rst_level", 32'(level), 5);
    chk("pre_rst_head", 32'(m_data), 32'h20B);
    in_data = 32'h555; in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_m_valid", 32'(m_valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_drop_cnt", 32'(drop_cnt), 0);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_m_data", 32'(m_data), 0);
    #2 rst = 1'b1;
    step(); step();
    chk("post_rst_valid", 32'(m_valid), 0);
    chk("post_rst_level", 32'(level), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
